// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, consecutive-sample debounce,
// press/release edge pulses and an optional hold-to-repeat pulse train.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_PERIOD   = 3,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned BTN_ACTIVE_LOW  = 0,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic key_pulse
);

  localparam logic             ACTIVE_LOW = (BTN_ACTIVE_LOW != 0);
  localparam logic             REPEAT_ON  = (REPEAT_EN != 0);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] db_cnt;
  logic             db_hit;
  logic             level_rise;
  logic             level_fall;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] rcnt_q;
  logic [CNT_W-1:0] rcnt_d;
  logic             repeat_d;

  // Polarity-normalised two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw ^ ACTIVE_LOW;
      sync_q2 <= sync_q1;
    end
  end

  // Level flips on the edge where the disagreement run reaches its limit
  always_comb begin
    db_hit     = (sync_q2 != btn_level) && (db_cnt == DB_LAST);
    level_rise = db_hit && sync_q2;
    level_fall = db_hit && !sync_q2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (sync_q2 == btn_level) begin
      db_cnt <= '0;
    end else if (db_hit) begin
      btn_level <= sync_q2;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Repeat FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Repeat FSM: next state; a release wins over any pending repeat
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (level_fall) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (REPEAT_ON && level_rise) begin
            state_d = ST_HOLD;
            rcnt_d  = '0;
          end
        end
        ST_HOLD: begin
          if (rcnt_q == DELAY_LAST) begin
            state_d = ST_REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (rcnt_q == PER_LAST) begin
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Repeat FSM: output decode
  always_comb begin
    repeat_d = 1'b0;
    if (!level_fall) begin
      case (state_q)
        ST_HOLD:   repeat_d = (rcnt_q == DELAY_LAST);
        ST_REPEAT: repeat_d = (rcnt_q == PER_LAST);
        default:   repeat_d = 1'b0;
      endcase
    end
  end

  // Registered pulse outputs, aligned with the first cycle of the new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      key_pulse     <= 1'b0;
    end else begin
      press_pulse   <= level_rise;
      release_pulse <= level_fall;
      repeat_pulse  <= repeat_d;
      key_pulse     <= level_rise | repeat_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed scenarios plus random button activity,
// compared edge-by-edge against a windowed history model of the button.
module tb_btn_debounce_pulse;

  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_level, press_pulse, release_pulse, repeat_pulse, key_pulse;

  int checks = 0;
  int errors = 0;

  // Model state: raw value applied before each edge since the last reset
  bit hist [0:8191];
  int e;
  bit mlvl;
  int last_flip;
  int rise_edge;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
    .REPEAT_EN(1), .BTN_ACTIVE_LOW(0), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // Synchronised value seen just before edge k: raw applied two edges earlier
  function automatic bit sync_before(int k);
    if (k - 2 >= 1) return hist[k - 2];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; mlvl = 1'b0; last_flip = 0; rise_edge = -1000000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".level"},   btn_level,     1'b0);
    check({tag, ".press"},   press_pulse,   1'b0);
    check({tag, ".release"}, release_pulse, 1'b0);
    check({tag, ".repeat"},  repeat_pulse,  1'b0);
    check({tag, ".key"},     key_pulse,     1'b0);
  endtask

  // Apply one raw value for one clock edge and check all outputs after it
  task automatic step(input bit raw);
    bit flip, ep, er, erp;
    btn_raw = raw;
    @(posedge clk);
    e++;
    hist[e] = raw;
    flip = (e >= D) && (e - D + 1 > last_flip);
    for (int k = e - D + 1; k <= e && flip; k++)
      if (sync_before(k) == mlvl) flip = 1'b0;
    ep = flip && !mlvl;
    er = flip && mlvl;
    if (flip) begin
      mlvl = ~mlvl;
      last_flip = e;
    end
    if (ep) rise_edge = e;
    erp = mlvl && !flip && (e - rise_edge >= DLY) && ((e - rise_edge - DLY) % PER == 0);
    #1;
    check("level",   btn_level,     mlvl);
    check("press",   press_pulse,   ep);
    check("release", release_pulse, er);
    check("repeat",  repeat_pulse,  erp);
    check("key",     key_pulse,     ep | erp);
  endtask

  task automatic hold(input bit raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_raw = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Held through reset release: rises only via debounce, then repeats
    hold(1'b1, 30);
    hold(1'b0, 12);

    // Clean press and release
    hold(1'b1, 8);
    hold(1'b0, 10);

    // Bounce with 3-cycle runs, then steady press
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end
    hold(1'b1, 12);

    // Short glitch while pressed
    hold(1'b0, 2);
    hold(1'b1, 30);

    // Async reset mid-repeat with the button still held
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    model_reset();
    hold(1'b1, 30);
    hold(1'b0, 10);

    // Random button activity: bursts of short bounce runs and long holds
    for (int seg = 0; seg < 150; seg++) begin
      bit v;
      int len;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(8, 40);
      else len = $urandom_range(1, D + 1);
      hold(v, len);
    end
    hold(1'b0, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
